// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Multi-cycle adder. It adds WIDTH-bit operands DIGIT bits per
//             clock, starting with the least significant digit. A carry
//             register links one digit to the next. Uses a start/busy/done
//             handshake.
//  Options  : Define SERIAL_ADDER_SUB_EN to add the 'sub' port. When the
//             latched sub is 1, operand B is inverted, so the result is
//             a - b - 1 + cin.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             start  - request, sampled only when idle
//             a, b   - WIDTH-bit operands, latched on an accepted start
//             cin    - carry in, latched on an accepted start
//             sub    - subtract select (only with SERIAL_ADDER_SUB_EN)
//             busy   - high while an operation is in flight
//             done   - one-cycle pulse; sum/cout/ovf are valid
//             sum    - result, held from done until the next accepted start
//             cout   - carry out of the MSB
//             ovf    - signed overflow (carry into MSB ^ carry out of MSB)
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_num_digits = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int c_cnt_w      = (c_num_digits > 1) ? $clog2(c_num_digits) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_num_digits - 1);

    // Reject configurations that cannot be split into whole digits.
    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: need WIDTH >= 1, 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_ovf;

    logic [WIDTH-1:0]     w_b_eff;
    logic [DIGIT:0]       w_c;
    logic [DIGIT-1:0]     w_dsum;
    logic [WIDTH-1:0]     w_sum_next;

    // Subtraction folds into the add by inverting B once at latch time.
    // After that, the datapath is a plain adder.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_eff = sub ? ~b : b;
`else
    assign w_b_eff = b;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit adder: DIGIT full adders in a ripple chain fed by the carry reg.
    // The operand registers shift right each cycle, so the current digit
    // is always in the low bits.
    // ------------------------------------------------------------------
    assign w_c[0] = r_carry;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            assign w_dsum[i] = r_a[i] ^ r_b[i] ^ w_c[i];
            assign w_c[i+1]  = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
        end
    endgenerate

    // New digits enter at the top of the result register. After N shifts,
    // the first (least significant) digit has reached bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_sum_full
            assign w_sum_next = w_dsum;
        end else begin : g_sum_shift
            assign w_sum_next = {w_dsum, r_sum[WIDTH-1:DIGIT]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_c[DIGIT];
            r_cnt   <= r_cnt + c_cnt_w'(1);
            r_sum   <= w_sum_next;
            if (w_last) begin
                // On the final digit, w_c[DIGIT-1] is the carry into the MSB.
                r_cout <= w_c[DIGIT];
                r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Directed self-checking bench for serial_adder. It drives two
//             instances from shared inputs: WIDTH=8/DIGIT=1 and
//             WIDTH=8/DIGIT=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cin   = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub   = 1'b0;
`endif

    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int n_done;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .ovf   (ovf1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents operands and a one-cycle start. On return, the accepting edge
    // has passed and the time is 1 ns after it.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(input bit use4, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((use4 ? done4 : done1) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_sum1",  sum1,  8'h00);
        check("rst_cout1", cout1, 0);
        check("rst_ovf1",  ovf1,  0);
        check("rst_busy4", busy4, 0);
        check("rst_sum4",  sum4,  8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy1", busy1, 0);

        // ---------------- 5A + 3C + 1 ----------------
        launch(8'h5A, 8'h3C, 1'b1);
        check("t1_busy_after_start", busy1, 1);
        wait_done(1'b0, cyc);
        check("t1_latency", cyc, 8);
        check("t1_sum",  sum1, 8'h97);
        check("t1_cout", cout1, 0);
        check("t1_ovf",  ovf1,  1);
        check("t1_busy_at_done", busy1, 1);
        check("t1_sum4", sum4, 8'h97);
        check("t1_ovf4", ovf4, 1);
        @(posedge clk); #1;
        check("t1_done_pulse", done1, 0);
        check("t1_busy_low", busy1, 0);
        a = 8'h11; b = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        check("t1_sum_hold", sum1, 8'h97);

        // ---------------- FF + 00 + 1 ----------------
        launch(8'hFF, 8'h00, 1'b1);
        wait_done(1'b0, cyc);
        check("t2a_latency", cyc, 8);
        check("t2a_sum",  sum1, 8'h00);
        check("t2a_cout", cout1, 1);
        check("t2a_ovf",  ovf1,  0);
        check("t2a_cout4", cout4, 1);
        @(posedge clk); #1;

        // ---------------- 7F + 01 + 0 ----------------
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(1'b0, cyc);
        check("t2b_sum",  sum1, 8'h80);
        check("t2b_cout", cout1, 0);
        check("t2b_ovf",  ovf1,  1);
        @(posedge clk); #1;

        // ---------------- start/operand changes during RUN ignored ----------------
        launch(8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        a = 8'hAA; b = 8'hBB; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 8'h01; b = 8'h02;
        n_done = 0;
        cyc = -1;
        for (int i = 4; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) begin
                n_done++;
                if (cyc < 0) begin
                    cyc = i;
                    check("t3_sum", sum1, 8'h46);
                    check("t3_busy_at_done", busy1, 1);
                end
            end else if (cyc > 0 && cyc == i - 1) begin
                check("t3_busy_after_done", busy1, 0);
            end
        end
        check("t3_latency", cyc, 8);
        check("t3_single_done", n_done, 1);

        // ---------------- reset in the middle of an operation ----------------
        launch(8'h77, 8'h11, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_busy", busy1, 0);
        check("t4_done", done1, 0);
        check("t4_sum",  sum1,  8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        launch(8'h01, 8'h01, 1'b0);
        wait_done(1'b0, cyc);
        check("t4_latency", cyc, 8);
        check("t4_sum2", sum1, 8'h02);
        @(posedge clk); #1;

        // ---------------- DIGIT=4: F0 + 0F ----------------
        launch(8'hF0, 8'h0F, 1'b0);
        wait_done(1'b1, cyc);
        check("t5_latency4", cyc, 2);
        check("t5_sum4",  sum4, 8'hFF);
        check("t5_cout4", cout4, 0);
        check("t5_ovf4",  ovf4,  0);
        wait_done(1'b0, cyc);
        check("t5_sum1", sum1, 8'hFF);
        @(posedge clk); #1;

`ifdef SERIAL_ADDER_SUB_EN
        // ---------------- subtract: 10 - 20 ----------------
        sub = 1'b1;
        launch(8'h10, 8'h20, 1'b1);
        wait_done(1'b0, cyc);
        check("t6_sum",  sum1, 8'hF0);
        check("t6_cout", cout1, 0);
        check("t6_ovf",  ovf1,  0);
        check("t6_sum4", sum4, 8'hF0);
        @(posedge clk); #1;
        // Restart in the cycle after done: 30 - 10.
        launch(8'h30, 8'h10, 1'b1);
        check("t6_restart_busy", busy1, 1);
        wait_done(1'b0, cyc);
        check("t6_restart_latency", cyc, 8);
        check("t6_restart_sum", sum1, 8'h20);
        check("t6_restart_cout", cout1, 1);
        sub = 1'b0;
        @(posedge clk); #1;
`else
        // Back-to-back restart in the cycle after done: 80 + 80.
        launch(8'h80, 8'h80, 1'b0);
        wait_done(1'b0, cyc);
        check("t6_sum", sum1, 8'h00);
        check("t6_cout", cout1, 1);
        check("t6_ovf", ovf1, 1);
        @(posedge clk); #1;
        launch(8'h0C, 8'h03, 1'b1);
        check("t6_restart_busy", busy1, 1);
        wait_done(1'b0, cyc);
        check("t6_restart_latency", cyc, 8);
        check("t6_restart_sum", sum1, 8'h10);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
